// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;
  localparam int ADDR_W      = 8;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int TAG_W       = 3;
  localparam int INDEX_W     = 3;
  localparam int OFFSET_W    = 2;
  localparam int LINE_W      = 32;
  localparam int MEM_ADDR_W  = TAG_W + INDEX_W;

  localparam int OFFSET_LSB  = 0;
  localparam int INDEX_LSB   = OFFSET_W;
  localparam int TAG_LSB     = OFFSET_W + INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef logic [LINE_W-1:0]   line_t;

  function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction

  function automatic index_t addr_index(input logic [ADDR_W-1:0] a);
    return a[INDEX_LSB +: INDEX_W];
  endfunction

  function automatic offset_t addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_LSB +: OFFSET_W];
  endfunction

  function automatic logic [7:0] line_byte(input line_t l, input offset_t o);
    return l[{o, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache, grouped as one bus.
interface dcache_if;
  import dcache_pkg::*;

  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [7:0]            writedata;
  logic [7:0]            readdata;
  logic                  busywait;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_address;
  line_t                 mem_writedata;
  line_t                 mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage; valid and dirty clear asynchronously on reset.
module dcache_array
  import dcache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  index_t     index,
  input  logic       byte_we,
  input  offset_t    byte_offset,
  input  logic [7:0] byte_data,
  input  logic       fill_we,
  input  tag_t       fill_tag,
  input  line_t      fill_line,
  output logic       valid,
  output logic       dirty,
  output tag_t       tag,
  output line_t      line
);
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  tag_t                  tag_q  [NUM_BLOCKS];
  line_t                 data_q [NUM_BLOCKS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (byte_we) begin
      data_q[index][{byte_offset, 3'b000} +: 8] <= byte_data;
    end
  end

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = data_q[index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: hit logic and miss FSM.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  dcache_if.slave  bus
);
  state_t                state;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [MEM_ADDR_W-1:0] mem_address_q;
  line_t                 mem_writedata_q;

  logic    read_req;
  logic    write_req;
  logic    req;
  tag_t    tag;
  index_t  index;
  offset_t offset;
  logic    valid;
  logic    dirty;
  tag_t    stored_tag;
  line_t   line;
  logic    hit;
  logic    byte_we;
  logic    fill_we;

  // Only a clean 1 counts as a request; a simultaneous read wins over write.
  assign read_req  = (bus.read === 1'b1);
  assign write_req = (bus.write === 1'b1) && !read_req;
  assign req       = read_req || write_req;

  assign tag    = addr_tag(bus.address);
  assign index  = addr_index(bus.address);
  assign offset = addr_offset(bus.address);

  assign hit     = valid && (stored_tag == tag);
  assign byte_we = (state == IDLE) && write_req && hit;
  assign fill_we = (state == UPDATE);

  dcache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .index       (index),
    .byte_we     (byte_we),
    .byte_offset (offset),
    .byte_data   (bus.writedata),
    .fill_we     (fill_we),
    .fill_tag    (tag),
    .fill_line   (bus.mem_readdata),
    .valid       (valid),
    .dirty       (dirty),
    .tag         (stored_tag),
    .line        (line)
  );

  assign bus.busywait      = (state != IDLE) || (req && !hit);
  assign bus.readdata      = ((state == IDLE) && read_req && hit) ? line_byte(line, offset) : 8'h00;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  // Strobes are registered so an async reset drops them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (valid && dirty) begin
              state           <= WRITEBACK;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {stored_tag, index};
              mem_writedata_q <= line;
            end else begin
              state         <= FETCH;
              mem_read_q    <= 1'b1;
              mem_address_q <= {tag, index};
            end
          end
        end
        WRITEBACK: begin
          if (!bus.mem_busywait) begin
            state         <= FETCH;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= {tag, index};
          end
        end
        FETCH: begin
          if (!bus.mem_busywait) begin
            state      <= UPDATE;
            mem_read_q <= 1'b0;
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, reset corner cases, random traffic vs a flat-memory model.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();

  dcache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Block memory with a programmable number of busy cycles per access.
  logic [31:0] mem_img [64];
  bit          seeded = 1'b0;
  int          cnt = 0;
  int          mem_lat = 1;
  int          wb_count = 0;
  int          fetch_count = 0;
  logic [5:0]  last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  logic [5:0]  last_fetch_addr = '0;
  logic [5:0]  rd_addr = '0;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    case (i)
      1:       return 32'h44332211;
      4:       return 32'hDDCCBBAA;
      9:       return 32'h88776655;
      12:      return 32'h0C0B0A09;
      default: return {b ^ 8'hA5, b, 8'h3C, b + 8'd1};
    endcase
  endfunction

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt < mem_lat);
  assign bus.mem_readdata = mem_img[rd_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      if (!seeded) begin
        for (int i = 0; i < 64; i++) mem_img[i] <= init_word(i);
        seeded <= 1'b1;
      end
    end else if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_busywait) begin
        cnt <= cnt + 1;
      end else begin
        cnt <= 0;
        if (bus.mem_write) begin
          mem_img[bus.mem_address] <= bus.mem_writedata;
          last_wb_addr <= bus.mem_address;
          last_wb_data <= bus.mem_writedata;
          wb_count     <= wb_count + 1;
        end
        if (bus.mem_read) begin
          rd_addr         <= bus.mem_address;
          last_fetch_addr <= bus.mem_address;
          fetch_count     <= fetch_count + 1;
        end
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts just after a rising edge; returns stall cycles and the byte seen once unstalled.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        input int lat, output int stall, output logic [7:0] rdata);
    mem_lat       = lat;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
    @(negedge clk);
    stall = 0;
    while (bus.busywait === 1'b1 && stall < 300) begin
      @(negedge clk);
      stall++;
    end
    rdata = bus.readdata;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    int          lat;
    int          stall;
    logic [7:0]  rdata;
    bit          fetch;
    logic [5:0]  fetch_addr;
    bit          wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
  } vec_t;

  vec_t vecs [13];

  logic [7:0] ref_bytes [256];
  bit         m_valid   [8];
  bit         m_dirty   [8];
  logic [2:0] m_tag     [8];

  task automatic sync_model();
    logic [31:0] w;
    for (int b = 0; b < 64; b++) begin
      w = mem_img[b];
      for (int k = 0; k < 4; k++) ref_bytes[b*4 + k] = w[8*k +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  initial begin
    int          stall;
    int          f0;
    int          w0;
    int          k;
    logic [7:0]  rdata;
    logic [31:0] w;

    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;

    #2;
    check("reset_busywait", bus.busywait, 1'b0);
    check("reset_mem_read", bus.mem_read, 1'b0);
    check("reset_mem_write", bus.mem_write, 1'b0);
    check("reset_readdata", bus.readdata, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("pulse_busywait", bus.busywait, 1'b0);
    check("pulse_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;

    //           rd    wr    addr   wd     lat st  rdata  f  faddr  wb  waddr  wdata
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1,  4, 8'h01, 1, 6'h00, 0, 6'h00, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h04, 8'h00, 5,  8, 8'h11, 1, 6'h01, 0, 6'h00, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 8'h05, 8'h00, 5,  0, 8'h22, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 8'h06, 8'hAB, 5,  0, 8'h00, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 8'h06, 8'h00, 5,  0, 8'hAB, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 8'h26, 8'h00, 2,  8, 8'h77, 1, 6'h09, 1, 6'h01, 32'h44AB2211};
    vecs[6]  = '{1'b0, 1'b1, 8'h10, 8'h5A, 3,  6, 8'h00, 1, 6'h04, 0, 6'h00, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 8'h10, 8'h00, 3,  0, 8'h5A, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 8'h11, 8'h00, 3,  0, 8'hBB, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 8'h12, 8'hFF, 3,  0, 8'hCC, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 8'h12, 8'h00, 3,  0, 8'hCC, 0, 6'h00, 0, 6'h00, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 8'h30, 8'h00, 0,  4, 8'h09, 1, 6'h0C, 1, 6'h04, 32'hDDCCBB5A};
    vecs[12] = '{1'b1, 1'b0, 8'h10, 8'h00, 0,  3, 8'h5A, 1, 6'h04, 0, 6'h00, 32'h0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      f0 = fetch_count;
      w0 = wb_count;
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].lat, stall, rdata);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].stall);
      check($sformatf("vec%0d_readdata", i), rdata, vecs[i].rdata);
      check($sformatf("vec%0d_fetches", i), fetch_count - f0, vecs[i].fetch ? 1 : 0);
      check($sformatf("vec%0d_writebacks", i), wb_count - w0, vecs[i].wb ? 1 : 0);
      if (vecs[i].fetch) check($sformatf("vec%0d_fetch_addr", i), last_fetch_addr, vecs[i].fetch_addr);
      if (vecs[i].wb) begin
        check($sformatf("vec%0d_wb_addr", i), last_wb_addr, vecs[i].wb_addr);
        check($sformatf("vec%0d_wb_data", i), last_wb_data, vecs[i].wb_data);
      end
    end

    // Reset in the middle of a fetch: strobes drop at once, the line stays invalid.
    mem_lat     = 10;
    bus.read    = 1'b1;
    bus.address = 8'h38;
    k = 0;
    while (bus.mem_read !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("midfetch_started", bus.mem_read, 1'b1);
    check("midfetch_addr", bus.mem_address, 6'h0E);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midfetch_read_drop", bus.mem_read, 1'b0);
    check("midfetch_write_drop", bus.mem_write, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    w = init_word(14);
    do_req(1'b1, 1'b0, 8'h38, 8'h00, 2, stall, rdata);
    check("after_reset_stall", stall, 5);
    check("after_reset_readdata", rdata, w[7:0]);

    // Random traffic against a flat byte-memory model plus a set-occupancy model.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sync_model();
    for (int it = 0; it < 200; it++) begin
      logic       rd;
      logic       wr;
      logic       erd;
      logic       ewr;
      logic       hit;
      logic       exp_wb;
      logic [7:0] a;
      logic [7:0] wd;
      logic [7:0] exp_rd;
      logic [2:0] idx;
      logic [2:0] tg;
      logic [5:0] vblk;
      logic [31:0] exp_wdata;
      int         lat;
      int         exp_stall;

      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 95));
      wd  = 8'($urandom);
      lat = int'($urandom_range(0, 3));
      erd = rd;
      ewr = wr && !rd;
      idx = a[4:2];
      tg  = a[7:5];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      exp_wb = 1'b0;
      exp_wdata = '0;
      vblk = {m_tag[idx], idx};
      if (!erd && !ewr) begin
        exp_stall = 0;
      end else begin
        exp_wb = !hit && m_valid[idx] && m_dirty[idx];
        exp_stall = hit ? 0 : (exp_wb ? 2*lat + 4 : lat + 3);
        exp_wdata = {ref_bytes[vblk*4 + 3], ref_bytes[vblk*4 + 2], ref_bytes[vblk*4 + 1], ref_bytes[vblk*4]};
        if (!hit) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = tg;
          m_dirty[idx] = 1'b0;
        end
        if (ewr) begin
          m_dirty[idx] = 1'b1;
          ref_bytes[a] = wd;
        end
      end
      exp_rd = erd ? ref_bytes[a] : 8'h00;

      f0 = fetch_count;
      w0 = wb_count;
      do_req(rd, wr, a, wd, lat, stall, rdata);
      check($sformatf("rnd%0d_stall", it), stall, exp_stall);
      check($sformatf("rnd%0d_readdata", it), rdata, exp_rd);
      check($sformatf("rnd%0d_fetches", it), fetch_count - f0, ((erd || ewr) && !hit) ? 1 : 0);
      check($sformatf("rnd%0d_writebacks", it), wb_count - w0, exp_wb ? 1 : 0);
      if (exp_wb) begin
        check($sformatf("rnd%0d_wb_addr", it), last_wb_addr, vblk);
        check($sformatf("rnd%0d_wb_data", it), last_wb_data, exp_wdata);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU datapath (driven by the control unit's READ/WRITE for lwd/lwi/swd/swi) and the 32-bit-block data memory.
- Stalls the CPU through BUSYWAIT on misses.
- Sequences block write-back and block fetch with the memory's busywait handshake.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- NUM_BLOCKS, 8, number of cache lines (index width = log2 = 3).
- BLOCK_BYTES, 4, bytes per line (offset width = 2; line = 32 bits).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; one clock; reset is asynchronous and active-high.
- READ  in  1  CPU load request (from control unit).
- WRITE  in  1  CPU store request (from control unit).
- ADDRESS  in  8  CPU byte address (ALU result).
- WRITEDATA  in  8  store byte (register file out1).
- READDATA  out  8  load byte to register file.
- BUSYWAIT  out  1  CPU stall; PC and register write are held while high.
- MEM_READ  out  1  memory block read strobe.
- MEM_WRITE  out  1  memory block write strobe.
- MEM_ADDRESS  out  6  memory block address {tag,index}.
- MEM_WRITEDATA  out  32  victim line data.
- MEM_READDATA  in  32  fetched line data.
- MEM_BUSYWAIT  in  1  memory busy; high while an access is in progress.

Behaviour:
- Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0]. Byte k of a line occupies bits [8k+7:8k].
- Request valid only when READ or WRITE is exactly 1. X/Z values count as no request. If both are 1, READ wins and WRITE is ignored.
- Hit = valid[index] and tag_store[index] == tag, evaluated combinationally in IDLE.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - Read hit: READDATA = selected byte combinationally, BUSYWAIT = 0, zero stall.
  - Write hit: BUSYWAIT = 0; byte written and dirty set at the next rising edge.
  - Miss, line clean or invalid: BUSYWAIT = 1 combinationally; next state FETCH.
  - Miss, line valid and dirty: BUSYWAIT = 1 combinationally; next state WRITEBACK.
- WRITEBACK:
  - MEM_WRITE = 1, MEM_ADDRESS = {tag_store[index], index}, MEM_WRITEDATA = line data.
  - Leave to FETCH at the first rising edge with MEM_BUSYWAIT = 0, after at least one cycle in the state.
- FETCH:
  - MEM_READ = 1, MEM_ADDRESS = {tag, index}.
  - Leave to UPDATE under the same rule as WRITEBACK.
- UPDATE (1 cycle): at its closing edge, line = MEM_READDATA, tag stored, valid = 1, dirty = 0; next state IDLE.
- After UPDATE, the pending request re-evaluates as a hit: read data returns or the write completes. A write miss therefore ends dirty.
- BUSYWAIT is 1 in every non-IDLE state and 0 in IDLE on a hit or with no request.
- MEM_READ and MEM_WRITE are never 1 simultaneously. Both are 0 in IDLE and UPDATE.
- ADDRESS, READ, WRITE and WRITEDATA are held stable by the CPU while BUSYWAIT = 1. The controller does not register them.
- Reset values: state IDLE; all valid and dirty bits 0; MEM_READ = MEM_WRITE = 0; BUSYWAIT = 0; READDATA = 0 when no read hit. Tag and data arrays need not be cleared.
- Reset mid-operation (WRITEBACK or FETCH): strobes drop immediately. The line is left invalid and the partial memory write is abandoned.
- Latency:
  - Read/write hit: 0 stall cycles.
  - Clean miss: 1 (IDLE→FETCH) + N memory cycles + 1 (UPDATE).
  - Dirty miss: adds the write-back time before the fetch.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum (IDLE, WRITEBACK, FETCH, UPDATE);
  - TAG_W = 3, INDEX_W = 3, OFFSET_W = 2, LINE_W = 32;
  - field-extract constants.
- Sub-module dcache_array: the tag/valid/dirty/data storage, with async-clear of valid/dirty on RESET, a byte-write port and a line-fill port.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
- RESET pulse mid-cycle → BUSYWAIT = 0, MEM_READ = MEM_WRITE = 0 asynchronously; a read of 0x00 then misses.
- Cold read ADDRESS = 0x04, memory returns 0x44332211 after 5 busy cycles → MEM_READ with MEM_ADDRESS = 0x01; BUSYWAIT falls after UPDATE; READDATA = 0x11.
- Read 0x05 immediately after → hit, BUSYWAIT stays 0, READDATA = 0x22.
- Write 0x06 data 0xAB (hit) → no stall, line becomes 0x44AB2211, dirty = 1. Then read 0x26 (same index, tag 1) → MEM_WRITE with MEM_ADDRESS = 0x01, data 0x44AB2211; then MEM_READ with MEM_ADDRESS = 0x09; READDATA = byte 2 of the fetched line.
- Write miss 0x10 data 0x5A on an invalid line → FETCH of block 0x04, then byte 0 = 0x5A and dirty = 1; the following read of 0x10 returns 0x5A with no stall.
- RESET asserted during FETCH → strobes drop the same instant; after release, a read of the same address misses again. READ = WRITE = 1 → treated as a read with no store.
